// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register-write scoreboard.
//  - Default geometry (tracked depth, register select width, flush depth).
//  - Stage-entry field layout {vld, dst} at the default register width.
package reg_scoreboard_pkg;

  localparam int unsigned DepthDef      = 3;
  localparam int unsigned RegWDef       = 3;
  localparam int unsigned FlushDepthDef = 0;

  // One tracked in-flight write: valid flag above destination register.
  typedef struct packed {
    logic               vld;
    logic [RegWDef-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/sb_stage.sv
// One scoreboard pipeline stage: a vld/dst flop pair.
// Ports:
//  i_clk    clock
//  i_rst    synchronous reset, active-high (clears vld and dst)
//  i_kill   forces the next vld to 0 (flush)
//  i_vld    incoming valid from the younger stage (or decode)
//  i_dst    incoming destination register
//  o_vld    registered valid
//  o_dst    registered destination register
module sb_stage
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned REG_W = RegWDef
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_kill,
  input  logic             i_vld,
  input  logic [REG_W-1:0] i_dst,
  output logic             o_vld,
  output logic [REG_W-1:0] o_dst
);

  logic             r_vld;
  logic [REG_W-1:0] r_dst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= 1'b0;
      r_dst <= '0;
    end else begin
      r_vld <= i_vld & ~i_kill;
      r_dst <= i_dst;
    end
  end

  assign o_vld = r_vld;
  assign o_dst = r_dst;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-write scoreboard beside the decode stage.
// Tracks each register write from decode through writeback in a fixed-length shift
// pipeline (last stage = WB), stalls decode on RAW hazards the same-cycle RF bypass
// cannot cover, and raises a sticky error when the real writeback port disagrees
// with the tracked WB entry.
// Ports:
//  i_clk, i_rst               clock, synchronous active-high reset
//  i_id_valid/i_id_dst_en     decode holds an instruction / it writes i_id_dst
//  i_id_src{1,2}_en/_src{1,2} decode source reads
//  i_flush                    kill decode instruction and FLUSH_DEPTH youngest stages
//  i_wb_en/i_wb_sel           actual RF write port this cycle
//  o_stall                    hold decode/fetch, bubble into stage 0
//  o_busy                     any tracked stage valid
//  o_err                      sticky writeback mismatch
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH       = DepthDef,
  parameter int unsigned REG_W       = RegWDef,
  parameter int unsigned FLUSH_DEPTH = FlushDepthDef
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic             i_id_dst_en,
  input  logic [REG_W-1:0] i_id_dst,
  input  logic             i_id_src1_en,
  input  logic [REG_W-1:0] i_id_src1,
  input  logic             i_id_src2_en,
  input  logic [REG_W-1:0] i_id_src2,
  input  logic             i_flush,
  input  logic             i_wb_en,
  input  logic [REG_W-1:0] i_wb_sel,
  output logic             o_stall,
  output logic             o_busy,
  output logic             o_err
);

  logic [DEPTH-1:0]            w_vld;
  logic [DEPTH-1:0][REG_W-1:0] w_dst;
  logic [DEPTH-1:0]            w_kill;
  logic                        w_hit1;
  logic                        w_hit2;
  logic                        w_stall;
  logic                        w_issue;
  logic                        w_mismatch;
  logic                        r_err;

  // WB stage is left out of the compare: its value reaches decode via RF bypass.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 0; k < int'(DEPTH) - 1; k++) begin
      if (w_vld[k] && (w_dst[k] == i_id_src1)) w_hit1 = 1'b1;
      if (w_vld[k] && (w_dst[k] == i_id_src2)) w_hit2 = 1'b1;
    end
    w_hit1 = w_hit1 & i_id_src1_en;
    w_hit2 = w_hit2 & i_id_src2_en;
  end

  assign w_stall = i_id_valid & ~i_flush & (w_hit1 | w_hit2);
  assign w_issue = i_id_valid & i_id_dst_en & ~w_stall & ~i_flush;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    localparam bit Killable = (k <= int'(FLUSH_DEPTH));
    assign w_kill[k] = i_flush & Killable;

    if (k == 0) begin : g_head
      sb_stage #(
        .REG_W (REG_W)
      ) u_stage (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_kill (w_kill[k]),
        .i_vld  (w_issue),
        .i_dst  (i_id_dst),
        .o_vld  (w_vld[k]),
        .o_dst  (w_dst[k])
      );
    end else begin : g_tail
      sb_stage #(
        .REG_W (REG_W)
      ) u_stage (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_kill (w_kill[k]),
        .i_vld  (w_vld[k-1]),
        .i_dst  (w_dst[k-1]),
        .o_vld  (w_vld[k]),
        .o_dst  (w_dst[k])
      );
    end
  end

  assign w_mismatch = (i_wb_en != w_vld[DEPTH-1]) |
                      (i_wb_en & (i_wb_sel != w_dst[DEPTH-1]));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_mismatch;
    end
  end

  // Outputs are held low while reset is asserted, even before the flops clear.
  assign o_stall = w_stall & ~i_rst;
  assign o_busy  = (|w_vld) & ~i_rst;
  assign o_err   = r_err & ~i_rst;

endmodule
